// File: rtl/reaction_timer_if.sv
// Game-FSM <-> reaction timer bus: state code and arm switch in, timing results out.
// The best_ms signal exists only when RT_BEST_SCORE_EN is defined.
interface reaction_timer_if;
  logic [2:0] cmd;
  logic       arm;
  logic [6:0] counter5;
  logic [9:0] counter1;
  logic [9:0] result_ms;
  logic       result_valid;
  logic       error_flag;
  logic       led_go;
`ifdef RT_BEST_SCORE_EN
  logic [9:0] best_ms;

  modport master (output cmd, arm,
                  input  counter5, counter1, result_ms, result_valid, error_flag, led_go, best_ms);
  modport slave  (input  cmd, arm,
                  output counter5, counter1, result_ms, result_valid, error_flag, led_go, best_ms);
`else
  modport master (output cmd, arm,
                  input  counter5, counter1, result_ms, result_valid, error_flag, led_go);
  modport slave  (input  cmd, arm,
                  output counter5, counter1, result_ms, result_valid, error_flag, led_go);
`endif
endinterface

// File: rtl/reaction_timer.sv
// Timebase and measurement datapath for the reaction-time game.
// Define RT_BEST_SCORE_EN to add the best (minimum) reaction-time register.
module reaction_timer #(
  parameter int MS_DIV   = 50_000,
  parameter int MS_PER_S = 1000
) (
  input logic             clk,
  input logic             rstn,
  reaction_timer_if.slave bus
);

  localparam int MSW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int SSW = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam logic [MSW-1:0] MS_LAST = MSW'(MS_DIV - 1);
  localparam logic [SSW-1:0] S_LAST  = SSW'(MS_PER_S - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WAIT  = 3'd1;
  localparam logic [2:0] REACT = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]     r_cmdQ;
  logic           r_armQ;
  logic [2:0]     r_prevPhase;
  logic [MSW-1:0] r_msCnt;
  logic [SSW-1:0] r_sCnt;
  logic [6:0]     r_counter5;
  logic [9:0]     r_counter1;
  logic [9:0]     r_resultMs;
  logic           r_resultValid;
  logic           r_errorFlag;
  logic           r_ledGo;

  logic [2:0] w_phase;
  logic       w_clear;
  logic       w_reactEntry;
  logic       w_waitClean;
  logic       w_doneEntry;
  logic       w_msWrap;
  logic       w_msTick;
  logic       w_sTick;

  always_comb begin
    w_phase = IDLE;
    case (r_cmdQ)
      3'b001:  w_phase = WAIT;
      3'b010:  w_phase = REACT;
      3'b100:  w_phase = DONE;
      3'b011:  w_phase = ERR;
      default: w_phase = IDLE;
    endcase
  end

  assign w_clear      = (w_phase == IDLE) && !r_armQ;
  assign w_reactEntry = (w_phase == REACT) && (r_prevPhase != REACT);
  assign w_waitClean  = (w_phase == WAIT) && (r_prevPhase == IDLE) && (r_counter5 == 7'd0);
  assign w_doneEntry  = (w_phase == DONE) && (r_prevPhase != DONE);
  assign w_msWrap     = (r_msCnt == MS_LAST);
  assign w_msTick     = w_msWrap && !w_clear && !w_reactEntry && !w_waitClean;
  assign w_sTick      = w_msTick && (r_sCnt == S_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmdQ      <= 3'b000;
      r_armQ      <= 1'b0;
      r_prevPhase <= IDLE;
    end else begin
      r_cmdQ      <= bus.cmd;
      r_armQ      <= bus.arm;
      r_prevPhase <= w_phase;
    end
  end

  // Entry restarts load 1: the phase-entry edge already counts as the first clk of the window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_msCnt <= '0;
      r_sCnt  <= '0;
    end else if (w_clear) begin
      r_msCnt <= '0;
      r_sCnt  <= '0;
    end else if (w_reactEntry) begin
      r_msCnt <= MSW'(1);
    end else if (w_waitClean) begin
      r_msCnt <= MSW'(1);
      r_sCnt  <= '0;
    end else begin
      r_msCnt <= w_msWrap ? '0 : r_msCnt + MSW'(1);
      if (w_msTick)
        r_sCnt <= (r_sCnt == S_LAST) ? '0 : r_sCnt + SSW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_counter5    <= 7'd0;
      r_counter1    <= 10'd0;
      r_resultMs    <= 10'd0;
      r_resultValid <= 1'b0;
      r_errorFlag   <= 1'b0;
      r_ledGo       <= 1'b0;
    end else begin
      r_errorFlag <= (w_phase == ERR);
      r_ledGo     <= (w_phase == REACT);
      if (w_clear) begin
        r_counter5    <= 7'd0;
        r_counter1    <= 10'd0;
        r_resultMs    <= 10'd0;
        r_resultValid <= 1'b0;
      end else begin
        if ((w_phase == WAIT) && w_sTick && (r_counter5 != 7'd127))
          r_counter5 <= r_counter5 + 7'd1;
        if (w_reactEntry)
          r_counter1 <= 10'd0;
        else if ((w_phase == REACT) && w_msTick && (r_counter1 != 10'd1023))
          r_counter1 <= r_counter1 + 10'd1;
        if (w_doneEntry) begin
          r_resultMs    <= r_counter1;
          r_resultValid <= 1'b1;
        end
      end
    end
  end

  assign bus.counter5     = r_counter5;
  assign bus.counter1     = r_counter1;
  assign bus.result_ms    = r_resultMs;
  assign bus.result_valid = r_resultValid;
  assign bus.error_flag   = r_errorFlag;
  assign bus.led_go       = r_ledGo;

`ifdef RT_BEST_SCORE_EN
  logic [9:0] r_bestMs;

  // Updated on the capture edge that raises result_valid; only rstn restores it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_bestMs <= 10'd1023;
    else if (w_doneEntry && !r_resultValid && (r_counter1 < r_bestMs))
      r_bestMs <= r_counter1;
  end

  assign bus.best_ms = r_bestMs;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: time-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations (MS_DIV=4, MS_PER_S=10).
module tb_reaction_timer;

  localparam int MS_DIV   = 4;
  localparam int MS_PER_S = 10;

  typedef enum int {P_IDLE, P_WAIT, P_REACT, P_DONE, P_ERR} tbPhase_t;

  logic clk;
  logic rstn;
  int   tests;
  int   failures;
  int   prevC5;

  reaction_timer_if bus();

  reaction_timer #(.MS_DIV(MS_DIV), .MS_PER_S(MS_PER_S)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tbPhase_t phaseOf(input logic [2:0] c);
    case (c)
      3'b001:  return P_WAIT;
      3'b010:  return P_REACT;
      3'b100:  return P_DONE;
      3'b011:  return P_ERR;
      default: return P_IDLE;
    endcase
  endfunction

  // Reference model: ticks come from absolute time since the last alignment point,
  // counters are plain saturating integers.
  logic [2:0] mCmdQ;
  logic       mArmQ;
  tbPhase_t   mPh;
  tbPhase_t   mPrevPh;
  int         mCyc;
  int         mT0;
  int         mMsSinceS;
  int         mC5;
  int         mC1;
  int         mRes;
  int         mRv;
  int         mErr;
  int         mGo;
`ifdef RT_BEST_SCORE_EN
  int         mBest;
`endif
  logic mClear, mReactEntry, mWaitClean, mDoneEntry, mMsTick, mSTick;

  assign mPh         = phaseOf(mCmdQ);
  assign mClear      = (mPh == P_IDLE) && !mArmQ;
  assign mReactEntry = (mPh == P_REACT) && (mPrevPh != P_REACT);
  assign mWaitClean  = (mPh == P_WAIT) && (mPrevPh == P_IDLE) && (mC5 == 0);
  assign mDoneEntry  = (mPh == P_DONE) && (mPrevPh != P_DONE);
  assign mMsTick     = !mClear && !mReactEntry && !mWaitClean &&
                       (mCyc > mT0) && (((mCyc - mT0) % MS_DIV) == 0);
  assign mSTick      = mMsTick && (((mMsSinceS + 1) % MS_PER_S) == 0);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mCmdQ     <= 3'b000;
      mArmQ     <= 1'b0;
      mPrevPh   <= P_IDLE;
      mCyc      <= 0;
      mT0       <= -1;
      mMsSinceS <= 0;
      mC5       <= 0;
      mC1       <= 0;
      mRes      <= 0;
      mRv       <= 0;
      mErr      <= 0;
      mGo       <= 0;
`ifdef RT_BEST_SCORE_EN
      mBest     <= 1023;
`endif
    end else begin
      mCmdQ   <= bus.cmd;
      mArmQ   <= bus.arm;
      mPrevPh <= mPh;
      mCyc    <= mCyc + 1;
      if (mClear) begin
        mT0       <= mCyc;
        mMsSinceS <= 0;
      end else if (mReactEntry) begin
        mT0 <= mCyc - 1;
      end else if (mWaitClean) begin
        mT0       <= mCyc - 1;
        mMsSinceS <= 0;
      end else if (mMsTick) begin
        mMsSinceS <= mMsSinceS + 1;
      end
      mErr <= (mPh == P_ERR) ? 1 : 0;
      mGo  <= (mPh == P_REACT) ? 1 : 0;
      if (mClear) begin
        mC5  <= 0;
        mC1  <= 0;
        mRes <= 0;
        mRv  <= 0;
      end else begin
        if ((mPh == P_WAIT) && mSTick)
          mC5 <= (mC5 >= 127) ? 127 : mC5 + 1;
        if (mReactEntry)
          mC1 <= 0;
        else if ((mPh == P_REACT) && mMsTick)
          mC1 <= (mC1 >= 1023) ? 1023 : mC1 + 1;
        if (mDoneEntry) begin
          mRes <= mC1;
          mRv  <= 1;
`ifdef RT_BEST_SCORE_EN
          if (mRv == 0 && mC1 < mBest)
            mBest <= mC1;
`endif
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      if (failures <= 20)
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      checkOutput("model_counter5", int'(bus.counter5), mC5);
      checkOutput("model_counter1", int'(bus.counter1), mC1);
      checkOutput("model_result_ms", int'(bus.result_ms), mRes);
      checkOutput("model_result_valid", int'(bus.result_valid), mRv);
      checkOutput("model_error_flag", int'(bus.error_flag), mErr);
      checkOutput("model_led_go", int'(bus.led_go), mGo);
`ifdef RT_BEST_SCORE_EN
      checkOutput("model_best_ms", int'(bus.best_ms), mBest);
`endif
    end
  end

  task automatic applyStimulus(input logic [2:0] c, input logic a, input int n);
    bus.cmd = c;
    bus.arm = a;
    repeat (n) @(negedge clk);
  endtask

  task automatic doRun(input int ms);
    applyStimulus(3'b000, 1'b0, 2);
    applyStimulus(3'b010, 1'b1, MS_DIV * ms);
    applyStimulus(3'b100, 1'b1, 2);
    checkOutput("run_result_ms", int'(bus.result_ms), ms);
    checkOutput("run_result_valid", int'(bus.result_valid), 1);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.cmd  = 3'b000;
    bus.arm  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    applyStimulus(3'b000, 1'b0, 3);
    checkOutput("reset_counter5", int'(bus.counter5), 0);
    checkOutput("reset_result_valid", int'(bus.result_valid), 0);

    applyStimulus(3'b001, 1'b1, 200);
    applyStimulus(3'b000, 1'b1, 2);
    checkOutput("start_counter5_200clk", int'(bus.counter5), 5);

    prevC5 = int'(bus.counter5);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(3'b000, 1'b1, 7);
      checkOutput("armed_idle_c5_monotonic", int'(int'(bus.counter5) >= prevC5), 1);
      prevC5 = int'(bus.counter5);
      applyStimulus(3'b001, 1'b1, 23);
      checkOutput("armed_wait_c5_monotonic", int'(int'(bus.counter5) >= prevC5), 1);
      prevC5 = int'(bus.counter5);
    end
    applyStimulus(3'b000, 1'b0, 2);
    checkOutput("disarm_clears_counter5", int'(bus.counter5), 0);

    applyStimulus(3'b010, 1'b1, MS_DIV * 250);
    checkOutput("react_led_go", int'(bus.led_go), 1);
    applyStimulus(3'b100, 1'b1, 2);
    checkOutput("done_result_ms", int'(bus.result_ms), 250);
    checkOutput("done_result_valid", int'(bus.result_valid), 1);
    checkOutput("done_led_go_off", int'(bus.led_go), 0);
    applyStimulus(3'b100, 1'b1, 1000);
    checkOutput("done_hold_result_ms", int'(bus.result_ms), 250);
    checkOutput("done_hold_result_valid", int'(bus.result_valid), 1);

    applyStimulus(3'b000, 1'b0, 2);
    applyStimulus(3'b010, 1'b1, MS_DIV * 1100);
    checkOutput("sat_counter1", int'(bus.counter1), 1023);
    applyStimulus(3'b010, 1'b1, 40);
    checkOutput("sat_counter1_stays", int'(bus.counter1), 1023);
    applyStimulus(3'b100, 1'b1, 2);
    checkOutput("sat_result_ms", int'(bus.result_ms), 1023);
    applyStimulus(3'b000, 1'b0, 2);
    applyStimulus(3'b001, 1'b1, MS_DIV * MS_PER_S * 130);
    checkOutput("sat_counter5", int'(bus.counter5), 127);

    applyStimulus(3'b000, 1'b0, 2);
    applyStimulus(3'b001, 1'b1, 121);
    checkOutput("err_pre_counter5", int'(bus.counter5), 3);
    applyStimulus(3'b011, 1'b1, 3);
    checkOutput("err_flag", int'(bus.error_flag), 1);
    checkOutput("err_counter5_frozen", int'(bus.counter5), 3);
    checkOutput("err_result_valid", int'(bus.result_valid), 0);
    applyStimulus(3'b011, 1'b1, 100);
    checkOutput("err_counter5_still", int'(bus.counter5), 3);

    applyStimulus(3'b000, 1'b0, 2);
    applyStimulus(3'b010, 1'b1, 149);
    checkOutput("pre_reset_counter1", int'(bus.counter1), 37);
    rstn = 1'b0;
    #1;
    checkOutput("async_reset_counter1", int'(bus.counter1), 0);
    checkOutput("async_reset_led_go", int'(bus.led_go), 0);
    checkOutput("async_reset_result_ms", int'(bus.result_ms), 0);
    checkOutput("async_reset_result_valid", int'(bus.result_valid), 0);
    checkOutput("async_reset_error_flag", int'(bus.error_flag), 0);
`ifdef RT_BEST_SCORE_EN
    checkOutput("async_reset_best_ms", int'(bus.best_ms), 1023);
`endif
    repeat (3) @(negedge clk);
    bus.cmd = 3'b000;
    bus.arm = 1'b0;
    rstn    = 1'b1;
    applyStimulus(3'b000, 1'b0, 2);
    checkOutput("post_reset_counter1", int'(bus.counter1), 0);
    checkOutput("post_reset_led_go", int'(bus.led_go), 0);

    doRun(300);
`ifdef RT_BEST_SCORE_EN
    checkOutput("best_after_300", int'(bus.best_ms), 300);
`endif
    doRun(180);
`ifdef RT_BEST_SCORE_EN
    checkOutput("best_after_180", int'(bus.best_ms), 180);
`endif
    doRun(240);
`ifdef RT_BEST_SCORE_EN
    checkOutput("best_after_240", int'(bus.best_ms), 180);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
